// File: rtl/chien_search_par.sv
// P-way parallel Chien search over GF(2^8): poly 0x11D, alpha = 0x02.
// Streams located roots per lane and flags a root-count mismatch with done.
module chien_search_par #(
  parameter int T = 4,
  parameter int P = 1,
  parameter int N = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4:0]         error_num,
  input  logic [8*(T+1)-1:0] elp,
  output logic [P-1:0]       loc_valid,
  output logic [8*P-1:0]     loc_pos,
  output logic [8*P-1:0]     loc_root,
  output logic               busy,
  output logic               done,
  output logic               fail
);

  localparam int         G      = (N + P - 1) / P;
  localparam logic [7:0] G_LAST = 8'(G - 1);
  localparam logic [4:0] T_MAX  = 5'(T);
  localparam logic [8:0] N_POS  = 9'(N);
  localparam logic [8:0] P_STEP = 9'(P);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // Only ever evaluated on constants, to build the multiplier coefficients.
  function automatic logic [7:0] gf_exp(input int e);
    logic [7:0] v;
    v = 8'h01;
    for (int n = 0; n < e % 255; n++) v = gf_mul(v, 8'h02);
    return v;
  endfunction

  localparam logic [7:0] A_STEP = gf_exp(P);

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;
  state_t state_reg, state_next;

  logic [7:0]     r_reg  [T+1];
  logic [7:0]     r_init [T+1];
  logic [7:0]     r_step [T+1];
  logic [7:0]     a_reg;
  logic [7:0]     g_reg;
  logic [8:0]     k_base_reg;
  logic [4:0]     count_reg;
  logic [4:0]     err_reg;
  logic [4:0]     count_next;
  logic [4:0]     hit_cnt;
  logic [5:0]     count_wide;
  logic [P-1:0]   hit;
  logic [8*P-1:0] lane_pos;
  logic [8*P-1:0] lane_root;
  logic           terminate;
  logic           trivial;

  for (genvar gj = 0; gj <= T; gj++) begin : g_coef
    localparam logic [7:0] INIT_C = gf_exp(gj);
    localparam logic [7:0] STEP_C = gf_exp(gj * P);
    assign r_init[gj] = gf_mul(elp[8*gj +: 8], INIT_C);
    assign r_step[gj] = gf_mul(r_reg[gj], STEP_C);
  end

  // a_reg tracks alpha^(g*P); lane i root value is a_reg * alpha^(i+1).
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    localparam logic [7:0] ROOT_C = gf_exp(gi + 1);
    logic [7:0] term [T+1];
    logic [7:0] sum;
    for (genvar gj = 0; gj <= T; gj++) begin : g_term
      localparam logic [7:0] LANE_C = gf_exp(gj * gi);
      assign term[gj] = gf_mul(r_reg[gj], LANE_C);
    end
    always_comb begin
      sum = 8'h00;
      for (int j = 0; j <= T; j++) sum = sum ^ term[j];
    end
    assign hit[gi] = (sum == 8'h00) && ((k_base_reg + 9'(gi)) < N_POS);
    assign lane_pos[8*gi +: 8]  = k_base_reg[7:0] + 8'(gi);
    assign lane_root[8*gi +: 8] = gf_mul(a_reg, ROOT_C);
  end

  always_comb begin
    hit_cnt = 5'd0;
    for (int i = 0; i < P; i++) hit_cnt = hit_cnt + 5'(hit[i]);
    count_wide = {1'b0, count_reg} + {1'b0, hit_cnt};
    count_next = (count_wide > 6'd31) ? 5'd31 : count_wide[4:0];
    terminate  = (count_next >= err_reg) || (g_reg == G_LAST);
  end

  assign trivial = (error_num == 5'd0) || (error_num > T_MAX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = IDLE;
      SEARCH:  if (terminate) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start) state_next = trivial ? FINISH : SEARCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= T; j++) r_reg[j] <= 8'h00;
      a_reg      <= 8'h00;
      g_reg      <= 8'h00;
      k_base_reg <= 9'd0;
      count_reg  <= 5'd0;
      err_reg    <= 5'd0;
      loc_valid  <= '0;
      loc_pos    <= '0;
      loc_root   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (start) begin
        // A start at any time restarts from group 0 and drops pending results.
        for (int j = 0; j <= T; j++) r_reg[j] <= r_init[j];
        a_reg      <= 8'h01;
        g_reg      <= 8'h00;
        k_base_reg <= 9'd0;
        count_reg  <= 5'd0;
        err_reg    <= error_num;
        loc_valid  <= '0;
        done       <= trivial;
        fail       <= (error_num > T_MAX);
      end else if (state_reg == SEARCH) begin
        for (int j = 0; j <= T; j++) r_reg[j] <= r_step[j];
        a_reg      <= gf_mul(a_reg, A_STEP);
        g_reg      <= g_reg + 8'd1;
        k_base_reg <= k_base_reg + P_STEP;
        count_reg  <= count_next;
        loc_valid  <= hit;
        loc_pos    <= lane_pos;
        loc_root   <= lane_root;
        done       <= terminate;
        fail       <= terminate && (count_next != err_reg);
      end else begin
        loc_valid <= '0;
        done      <= 1'b0;
        fail      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chien_search_par.sv
// Directed bench for chien_search_par with P = 1, 4 and 16 instances (T = 4, N = 255).
// Cycle 1 is the cycle right after the one in which start is high.
module tb_chien_search_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v;
  logic [4:0]  error_num;
  logic [39:0] elp;

  logic [0:0]   v1;  logic [7:0]   pos1,  root1;  logic busy1,  done1,  fail1;
  logic [3:0]   v4;  logic [31:0]  pos4,  root4;  logic busy4,  done4,  fail4;
  logic [15:0]  v16; logic [127:0] pos16, root16; logic busy16, done16, fail16;

  chien_search_par #(.T(4), .P(1), .N(255)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .error_num(error_num), .elp(elp),
    .loc_valid(v1), .loc_pos(pos1), .loc_root(root1), .busy(busy1), .done(done1), .fail(fail1));
  chien_search_par #(.T(4), .P(4), .N(255)) u_p4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .error_num(error_num), .elp(elp),
    .loc_valid(v4), .loc_pos(pos4), .loc_root(root4), .busy(busy4), .done(done4), .fail(fail4));
  chien_search_par #(.T(4), .P(16), .N(255)) u_p16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .error_num(error_num), .elp(elp),
    .loc_valid(v16), .loc_pos(pos16), .loc_root(root16), .busy(busy16), .done(done16), .fail(fail16));

  int sel;
  logic [15:0]  mv;
  logic [127:0] mpos, mroot;
  logic         mbusy, mdone, mfail;

  always_comb begin
    mv = '0; mpos = '0; mroot = '0; mbusy = 1'b0; mdone = 1'b0; mfail = 1'b0;
    case (sel)
      0: begin mv[0] = v1[0]; mpos[7:0] = pos1; mroot[7:0] = root1;
               mbusy = busy1; mdone = done1; mfail = fail1; end
      1: begin mv[3:0] = v4; mpos[31:0] = pos4; mroot[31:0] = root4;
               mbusy = busy4; mdone = done4; mfail = fail4; end
      default: begin mv = v16; mpos = pos16; mroot = root16;
               mbusy = busy16; mdone = done16; mfail = fail16; end
    endcase
  end

  int n_assert = 0;
  int n_fail = 0;
  int alog [255];
  int lg [256];

  int rep_cyc[$];
  int rep_lane[$];
  int rep_pos[$];
  int rep_root[$];
  int done_cyc;
  int done_fail;
  int busy_gaps;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % 255];
  endfunction

  // Locator with roots at the given positions (-1 = unused): product of (1 + alpha^-(k+1) x).
  function automatic logic [39:0] roots_poly(input int ka, input int kb, input int kc);
    int c [5];
    int ks [3];
    int inv;
    logic [39:0] p;
    c[0] = 1; c[1] = 0; c[2] = 0; c[3] = 0; c[4] = 0;
    ks[0] = ka; ks[1] = kb; ks[2] = kc;
    for (int r = 0; r < 3; r++) begin
      if (ks[r] >= 0) begin
        inv = alog[254 - ks[r]];
        for (int j = 4; j >= 1; j--) c[j] = c[j] ^ gmul(c[j-1], inv);
      end
    end
    p = '0;
    for (int j = 0; j < 5; j++) p[8*j +: 8] = 8'(c[j]);
    return p;
  endfunction

  task automatic launch(input logic [4:0] en, input logic [39:0] poly);
    error_num = en;
    elp = poly;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic watch(input int maxc);
    rep_cyc.delete(); rep_lane.delete(); rep_pos.delete(); rep_root.delete();
    done_cyc = -1; done_fail = 0; busy_gaps = 0;
    for (int c = 1; c <= maxc; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (mv[i]) begin
          rep_cyc.push_back(c);
          rep_lane.push_back(i);
          rep_pos.push_back(int'(mpos[8*i +: 8]));
          rep_root.push_back(int'(mroot[8*i +: 8]));
        end
      end
      if (!mbusy) busy_gaps++;
      if (mdone) begin
        done_cyc = c;
        done_fail = int'(mfail);
      end
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic check_rep(input string tag, input int idx, input int cyc, input int lane,
                           input int pos, input int root);
    if (idx < rep_cyc.size()) begin
      check({tag, "_cyc"},  rep_cyc[idx],  cyc);
      check({tag, "_lane"}, rep_lane[idx], lane);
      check({tag, "_pos"},  rep_pos[idx],  pos);
      check({tag, "_root"}, rep_root[idx], root);
    end else begin
      check({tag, "_present"}, rep_cyc.size(), idx + 1);
    end
  endtask

  task automatic check_end(input string tag, input int nrep, input int dcyc, input int dfail);
    $display("txn %s: reports=%0d done_cycle=%0d fail=%0d", tag, rep_cyc.size(), done_cyc, done_fail);
    check({tag, "_reports"}, rep_cyc.size(), nrep);
    check({tag, "_done_cycle"}, done_cyc, dcyc);
    check({tag, "_fail"}, done_fail, dfail);
    check({tag, "_busy_gaps"}, busy_gaps, 0);
    check({tag, "_busy_after"}, int'(mbusy), 0);
    check({tag, "_done_after"}, int'(mdone), 0);
  endtask

  initial begin
    int v;
    v = 1;
    for (int e = 0; e < 255; e++) begin
      alog[e] = v;
      lg[v] = e;
      v = v << 1;
      if (v > 255) v = v ^ 'h11D;
    end
    lg[0] = 0;

    rst_n = 1'b0; start_v = '0; error_num = '0; elp = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_valid", int'(mv), 0);
      check("reset_busy", int'(mbusy), 0);
      check("reset_done", int'(mdone), 0);
      check("reset_fail", int'(mfail), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single root at k = 5 (Lambda1 = alpha^249 = 0x36), P = 1.
    sel = 0;
    launch(5'd1, 40'h00_0000_3601);
    watch(300);
    check_rep("single_k5", 0, 7, 0, 5, 'h40);
    check_end("single_k5", 1, 7, 0);

    // Roots at k = 0, 100, 254 with P = 4.
    sel = 1;
    launch(5'd3, roots_poly(0, 100, 254));
    watch(300);
    check_rep("p4_k0", 0, 2, 0, 0, 'h02);
    check_rep("p4_k100", 1, 27, 0, 100, alog[101]);
    check_rep("p4_k254", 2, 65, 2, 254, 'h01);
    check_end("p4_three", 3, 65, 0);

    // error_num = 2 but only one root (k = 7): full search, fail.
    sel = 0;
    launch(5'd2, roots_poly(7, -1, -1));
    watch(300);
    check_rep("short_k7", 0, 9, 0, 7, 'h1D);
    check_end("short_count", 1, 256, 1);

    // error_num above T.
    launch(5'd5, 40'h00_0000_3601);
    watch(10);
    check_end("over_t", 0, 1, 1);

    // Abort: restart in cycle 10 of a search for k = 20.
    launch(5'd1, roots_poly(20, -1, -1));
    watch(9);
    check("abort_pre_reports", rep_cyc.size(), 0);
    check("abort_pre_done", done_cyc, -1);
    launch(5'd1, roots_poly(20, -1, -1));
    watch(300);
    check_rep("abort_k20", 0, 22, 0, 20, alog[21]);
    check_end("abort_restart", 1, 22, 0);

    // P = 16: root at k = 254 in the partially masked last group.
    sel = 2;
    launch(5'd1, roots_poly(254, -1, -1));
    watch(300);
    check_rep("p16_k254", 0, 17, 14, 254, 'h01);
    check_end("p16_single", 1, 17, 0);

    // Masked lane 15 of group 15 would alias alpha^1 (the k = 0 root) if not masked.
    launch(5'd2, roots_poly(0, 254, -1));
    watch(300);
    check_rep("p16_mask_k0", 0, 2, 0, 0, 'h02);
    check_rep("p16_mask_k254", 1, 17, 14, 254, 'h01);
    check_end("p16_mask", 2, 17, 0);

    // Asynchronous reset in the middle of a search.
    sel = 0;
    launch(5'd1, roots_poly(200, -1, -1));
    repeat (4) @(negedge clk);
    check("areset_busy_before", int'(mbusy), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn async_reset: busy=%0d valid=%0d done=%0d", mbusy, mv, mdone);
    check("areset_busy", int'(mbusy), 0);
    check("areset_valid", int'(mv), 0);
    check("areset_done", int'(mdone), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // error_num = 0: immediate done, no reports.
    launch(5'd0, 40'h00_0000_3601);
    watch(10);
    check_end("zero_err", 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chien_search_par.md
Name: chien_search_par

Overview:
- Parametrised, P-way parallel Chien search for RS decoders over GF(2^8), primitive polynomial 0x11D, α = 0x02.
- Sits between the key-equation solver (Berlekamp-Massey) and the Forney/correction stage of the RS(255,K) FEC path.
- Evaluates an error-locator polynomial of degree up to T at P field points per cycle.
- Streams out root positions and root values instead of fixed per-error registers, and flags decoder failure.

Parameters:
- T, 4, maximum correctable errors (locator degree); range 1..16.
- P, 1, positions evaluated per cycle; range 1..16; need not divide N.
- N, 255, codeword length (positions searched); range T+1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; loads elp/error_num and begins a search.
- error_num  in  5  degree of Λ (errors expected); sampled on start.
- elp  in  8*(T+1)  Λ coefficients; Λj at bits [8j+7:8j]; sampled on start.
- loc_valid  out  P  lane i reports a root this cycle.
- loc_pos  out  8*P  lane i position k (bits [8i+7:8i]).
- loc_root  out  8*P  lane i root value α^(k+1).
- busy  out  1  search in progress.
- done  out  1  one-cycle completion pulse.
- fail  out  1  valid with done; root count ≠ error_num.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal coefficient registers and counters 0.
- Evaluation rule: position k ∈ [0, N-1] tests Λ(α^(k+1)); a root means the sum is 0, XOR over j = 0..T of Λj·α^(j(k+1)).
- FSM states:
  - IDLE: waits for start.
  - SEARCH: evaluates one group per cycle.
  - FINISH: one cycle; emits done/fail; returns to IDLE.
- On start:
  - If error_num == 0: go to FINISH; done pulses next cycle with fail = 0; no loc_valid.
  - If error_num > T: go to FINISH; done next cycle with fail = 1.
  - Otherwise: latch r_j = Λj·α^j, clear count and group index g, enter SEARCH.
- SEARCH group g covers k = g·P + i for lanes i = 0..P-1.
  - Lane i term j is r_j·α^(j·i), multiplied by a constant.
  - Each cycle r_j ← r_j·α^(j·P).
  - Lanes with k ≥ N are masked and never report.
- Outputs are registered: results of the group evaluated in cycle c appear in cycle c+1. loc_pos = k (8-bit), loc_root = α^(k+1).
- count accumulates popcount of the group's roots, saturating at 31.
- Termination, checked on the group's evaluation cycle:
  - count including this group ≥ error_num, or last group (g = ceil(N/P) − 1): go to FINISH.
  - done pulses in the same cycle as that group's registered loc_valid.
  - fail = (final count ≠ error_num).
- Extra roots: all roots found in the terminating group are reported, even if they overshoot error_num; fail then = 1.
- busy = 1 from the cycle after start through the done cycle, inclusive.
- start during SEARCH/FINISH aborts the current search:
  - Relatch inputs, restart from g = 0.
  - Pending done of the aborted search is suppressed.
  - loc_valid cleared next cycle.
- Latency (one root at k, P = 1, error_num = 1): loc_valid at cycle start+k+2, done in the same cycle.
- Full search with no early exit: done at start + ceil(N/P) + 1.
- Λ0 = 0 is not checked; the block searches as normal (position 0 root test degenerates).
- Asynchronous reset mid-search: immediate return to IDLE, all outputs 0.

Test Plan:
- P=1, T=4, error_num=1, Λ0 = 0x01, Λ1 = α^249 (others 0) -> single loc_valid with loc_pos = 5, loc_root = α^6 = 0x40; done in the same cycle (start + 7); fail = 0.
- P=4, T=4, Λ(x) = (1+α^-1·x)(1+α^-101·x)(1+α^-255·x) wait-free variant: roots at k = 0, 100, 254, error_num = 3 -> three reports at lanes 0/0/2, groups 0/25/63; done at start + 65; fail = 0.
- error_num = 2, Λ with only one root in the field (k = 7) -> one report; full search; done at start + 256 for P = 1; fail = 1.
- error_num = 0 -> done at start + 1; fail = 0; busy high for that 1 cycle; no loc_valid.
- error_num = 5 with T = 4 -> done at start + 1, fail = 1. Separately, start re-asserted at cycle 10 of a search -> prior results abandoned; timing restarts from the new start.
- P=16, N=255 (last group partially masked), root at k = 254 -> lane 14 of group 15 reports; lane 15 never asserts; done at start + 17.
